// File: rtl/mkio_receiver_if.sv
// Line pair and receive-result bundle for the MKIO Manchester receiver.
// The master side drives the line pair and observes the decoded words.
// The slave side is the receiver.
interface mkio_receiver_if;
    logic        DI1;
    logic        DI0;
    logic [15:0] data_rec;
    logic        cd_rec;
    logic        rdy_rec;
    logic        err_rec;
    logic        busy_rec;

    modport master (
        output DI1, DI0,
        input  data_rec, cd_rec, rdy_rec, err_rec, busy_rec
    );

    modport slave (
        input  DI1, DI0,
        output data_rec, cd_rec, rdy_rec, err_rec, busy_rec
    );
endinterface

// File: rtl/mkio_receiver.sv
// MKIO (MIL-STD-1553 style) Manchester word receiver.
// A word is 40 half-bits of 8 clocks each. Half-bits 0-5 are the sync,
// half-bits 6-37 are 16 data bit pairs (MSB first), and 38-39 are the
// odd-parity pair. Timing is slaved to the first active cycle of the
// word, and each half-bit is sampled at phase 3 of its 8-clock window.
//
//   state      | meaning
//   -----------+------------------------------------------------------
//   IDLE       | line quiet, waiting for the first active cycle
//   SYNC       | sampling half-bits 0-5, checking the sync shape
//   DATA       | sampling half-bits 6-39, shifting data, checking pairs
//   WAIT_IDLE  | bad sync seen, waiting for 8 quiet cycles before IDLE
module mkio_receiver (
    input  logic           clk,
    input  logic           reset,
    mkio_receiver_if.slave rx_bus
);

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_SYNC      = 2'd1;
    localparam logic [1:0] ST_DATA      = 2'd2;
    localparam logic [1:0] ST_WAIT_IDLE = 2'd3;

    localparam logic [2:0] PH_SAMPLE     = 3'd3;
    localparam logic [2:0] PH_LAST       = 3'd7;
    localparam logic [2:0] QUIET_RELOAD  = 3'd7;
    localparam logic [5:0] IDX_SYNC_LAST = 6'd5;
    localparam logic [5:0] IDX_SYNC_FLIP = 6'd3;
    localparam logic [5:0] IDX_PARITY    = 6'd38;
    localparam logic [5:0] IDX_LAST      = 6'd39;

    // Line synchronizer (two flops per rail).
    logic r_di1_m;
    logic r_di0_m;
    logic r_di1_s;
    logic r_di0_s;

    // Sequencer state.
    logic [1:0]  r_state;
    logic [2:0]  r_phase;
    logic [5:0]  r_index;
    logic [2:0]  r_quiet_tmr;

    // Word datapath.
    logic        r_cd;
    logic        r_first;
    logic [15:0] r_shift;
    logic        r_par;
    logic        r_man_err;

    // Registered outputs.
    logic [15:0] r_data_rec;
    logic        r_cd_rec;
    logic        r_rdy_rec;
    logic        r_err_rec;

    // Decoded per-cycle conditions.
    logic w_active;
    logic w_sample;
    logic w_start;
    logic w_in_word;
    logic w_smp;
    logic w_sync_exp;
    logic w_sync_bad;
    logic w_sync_fail;
    logic w_word_done;
    logic w_pair_bad;
    logic w_man_final;
    logic w_par_err;

    assign w_active  = r_di1_s ^ r_di0_s;
    assign w_sample  = r_di1_s;
    assign w_start   = (r_state == ST_IDLE) && w_active;
    assign w_in_word = (r_state == ST_SYNC) || (r_state == ST_DATA);
    assign w_smp     = w_in_word && (r_phase == PH_SAMPLE);

    // Half-bit 0 defines the sync type, so it can never mismatch itself;
    // the first three half-bits carry ~cd and the last three carry cd.
    assign w_sync_exp  = (r_index < IDX_SYNC_FLIP) ? ~r_cd : r_cd;
    assign w_sync_bad  = (r_index != 6'd0) && (w_sample != w_sync_exp);
    assign w_sync_fail = (r_state == ST_SYNC) && w_smp && w_sync_bad;
    assign w_word_done = (r_state == ST_DATA) && w_smp && (r_index == IDX_LAST);

    // Second half of a pair must be the complement of the first.
    assign w_pair_bad  = r_index[0] && (w_sample == r_first);

    // The final half-bit's own checks are folded in here, because the
    // result is reported in the very next cycle.
    assign w_man_final = r_man_err || !w_active || w_pair_bad;
    assign w_par_err   = ~(^{r_shift, r_par});

    // Two-flop synchronizer on each line rail.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_di1_m <= 1'b0;
            r_di0_m <= 1'b0;
            r_di1_s <= 1'b0;
            r_di0_s <= 1'b0;
        end else begin
            r_di1_m <= rx_bus.DI1;
            r_di0_m <= rx_bus.DI0;
            r_di1_s <= r_di1_m;
            r_di0_s <= r_di0_m;
        end
    end

    // State sequencing with phase/half-bit counters and the quiet-line timer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_phase     <= 3'd0;
            r_index     <= 6'd0;
            r_quiet_tmr <= 3'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_phase <= 3'd0;
                    r_index <= 6'd0;
                    if (w_active) begin
                        // The start cycle itself is phase 0.
                        r_state <= ST_SYNC;
                        r_phase <= 3'd1;
                    end
                end

                ST_SYNC: begin
                    if (w_sync_fail) begin
                        r_state     <= ST_WAIT_IDLE;
                        r_phase     <= 3'd0;
                        r_index     <= 6'd0;
                        r_quiet_tmr <= QUIET_RELOAD;
                    end else begin
                        r_phase <= r_phase + 3'd1;
                        if (r_phase == PH_LAST) begin
                            r_index <= r_index + 6'd1;
                            if (r_index == IDX_SYNC_LAST) begin
                                r_state <= ST_DATA;
                            end
                        end
                    end
                end

                ST_DATA: begin
                    r_phase <= r_phase + 3'd1;
                    if (r_phase == PH_LAST) begin
                        if (r_index == IDX_LAST) begin
                            // Back in IDLE exactly when a back-to-back
                            // word's first half-bit arrives.
                            r_state <= ST_IDLE;
                            r_index <= 6'd0;
                        end else begin
                            r_index <= r_index + 6'd1;
                        end
                    end
                end

                default: begin
                    r_phase <= 3'd0;
                    r_index <= 6'd0;
                    if (w_active) begin
                        r_quiet_tmr <= QUIET_RELOAD;
                    end else if (r_quiet_tmr == 3'd0) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_quiet_tmr <= r_quiet_tmr - 3'd1;
                    end
                end
            endcase
        end
    end

    // Sample capture: sync type, data shift register, parity bit, error flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cd      <= 1'b0;
            r_first   <= 1'b0;
            r_shift   <= 16'h0000;
            r_par     <= 1'b0;
            r_man_err <= 1'b0;
        end else if (w_start) begin
            r_man_err <= 1'b0;
        end else if (w_smp) begin
            if (!w_active) begin
                r_man_err <= 1'b1;
            end
            if (r_state == ST_SYNC) begin
                if (r_index == 6'd0) begin
                    r_cd <= ~w_sample;
                end
            end else begin
                if (!r_index[0]) begin
                    r_first <= w_sample;
                    if (r_index == IDX_PARITY) begin
                        r_par <= w_sample;
                    end else begin
                        r_shift <= {r_shift[14:0], w_sample};
                    end
                end else if (w_pair_bad) begin
                    r_man_err <= 1'b1;
                end
            end
        end
    end

    // Result registers: data/cd only change together with the ready pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_data_rec <= 16'h0000;
            r_cd_rec   <= 1'b0;
            r_rdy_rec  <= 1'b0;
            r_err_rec  <= 1'b0;
        end else begin
            r_rdy_rec <= 1'b0;
            r_err_rec <= 1'b0;
            if (w_sync_fail) begin
                r_err_rec <= 1'b1;
            end
            if (w_word_done) begin
                r_rdy_rec  <= 1'b1;
                r_err_rec  <= w_man_final || w_par_err;
                r_data_rec <= r_shift;
                r_cd_rec   <= r_cd;
            end
        end
    end

    assign rx_bus.data_rec = r_data_rec;
    assign rx_bus.cd_rec   = r_cd_rec;
    assign rx_bus.rdy_rec  = r_rdy_rec;
    assign rx_bus.err_rec  = r_err_rec;
    assign rx_bus.busy_rec = w_in_word;

endmodule

// File: tb/tb_mkio_receiver.sv
// Bench for mkio_receiver: a bench-side Manchester transmitter builds each
// word from its fields, and a queue of expected outcomes (computed from the
// word contents and any injected fault) is checked against every output
// pulse, while data_rec/cd_rec are checked to hold between pulses.
module tb_mkio_receiver;

    logic clk = 1'b0;
    logic reset = 1'b0;

    mkio_receiver_if bus_if ();

    mkio_receiver dut (
        .clk    (clk),
        .reset  (reset),
        .rx_bus (bus_if.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rdy;
        logic        err;
        logic [15:0] data;
        logic        cd;
        int          t_start;
    } exp_t;

    localparam int FAULT_NONE   = 0;
    localparam int FAULT_PARITY = 1;
    localparam int FAULT_PAIR11 = 2;
    localparam int FAULT_SYNC   = 3;

    exp_t        exp_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    logic [15:0] m_data  = 16'h0000;
    logic        m_cd    = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Single compare process: every cycle, away from the active edge.
    initial begin
        exp_t e;
        int   lat;
        forever begin
            @(negedge clk);
            if (reset) begin
                chk("reset_outputs",
                    {11'd0, bus_if.data_rec, bus_if.cd_rec, bus_if.rdy_rec,
                     bus_if.err_rec, bus_if.busy_rec}, 32'd0);
            end else begin
                if (bus_if.rdy_rec || bus_if.err_rec) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_pulse", {30'd0, bus_if.rdy_rec, bus_if.err_rec}, 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("rdy_rec", {31'd0, bus_if.rdy_rec}, {31'd0, e.rdy});
                        chk("err_rec", {31'd0, bus_if.err_rec}, {31'd0, e.err});
                        if (e.rdy) begin
                            lat = cyc - e.t_start;
                            chk("rdy_latency_window", {31'd0, (lat >= 315 && lat <= 325)}, 32'd1);
                            m_data = e.data;
                            m_cd   = e.cd;
                        end
                    end
                end else if (exp_q.size() > 0 && (cyc - exp_q[0].t_start) > 330) begin
                    chk("pulse_timeout", 32'd0, 32'd1);
                    void'(exp_q.pop_front());
                end
                chk("data_rec", {16'd0, bus_if.data_rec}, {16'd0, m_data});
                chk("cd_rec", {31'd0, bus_if.cd_rec}, {31'd0, m_cd});
            end
        end
    end

    task automatic idle(input int n);
        bus_if.DI1 = 1'b0;
        bus_if.DI0 = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Build a word from its fields, record its expected outcome, drive it.
    // n_half < 40 truncates the word (no outcome is expected for it).
    task automatic send_word(input logic cd, input logic [15:0] data, input int fault,
                             input int fbit, input logic [5:0] sync_pat, input int n_half);
        logic [39:0] smp;
        logic        p;
        logic [15:0] rx_data;
        int          n_send;
        exp_t        e;
        for (int i = 0; i < 3; i++) begin
            smp[39 - i]     = ~cd;
            smp[39 - i - 3] = cd;
        end
        if (fault == FAULT_SYNC) begin
            for (int i = 0; i < 6; i++) smp[39 - i] = sync_pat[5 - i];
        end
        for (int j = 0; j < 16; j++) begin
            smp[39 - (6 + 2 * j)] = data[15 - j];
            smp[39 - (7 + 2 * j)] = ~data[15 - j];
        end
        rx_data = data;
        if (fault == FAULT_PAIR11) begin
            smp[39 - (6 + 2 * (15 - fbit))] = 1'b1;
            smp[39 - (7 + 2 * (15 - fbit))] = 1'b1;
            rx_data[fbit] = 1'b1;
        end
        p = ~(^data);
        if (fault == FAULT_PARITY) p = ~p;
        smp[1] = p;
        smp[0] = ~p;

        n_send = (fault == FAULT_SYNC) ? 6 : n_half;
        e.t_start = cyc;
        e.cd      = cd;
        e.data    = rx_data;
        if (n_half >= 40 || fault == FAULT_SYNC) begin
            e.rdy = (fault != FAULT_SYNC);
            e.err = (fault != FAULT_NONE);
            exp_q.push_back(e);
        end
        for (int i = 0; i < n_send; i++) begin
            bus_if.DI1 = smp[39 - i];
            bus_if.DI0 = ~smp[39 - i];
            if (i == 20) chk("busy_mid_word", {31'd0, bus_if.busy_rec}, 32'd1);
            repeat (8) @(posedge clk);
            #1;
        end
        bus_if.DI1 = 1'b0;
        bus_if.DI0 = 1'b0;
    endtask

    initial begin
        int          fault;
        int          gap;
        logic [5:0]  pat;
        bus_if.DI1 = 1'b0;
        bus_if.DI0 = 1'b0;
        #1 reset = 1'b1;
        repeat (4) @(posedge clk);
        #1 reset = 1'b0;
        idle(10);
        chk("post_reset_busy", {31'd0, bus_if.busy_rec}, 32'd0);
        chk("post_reset_data", {16'd0, bus_if.data_rec}, 32'h0000);

        // Single command word.
        send_word(1'b1, 16'h1234, FAULT_NONE, 0, 6'd0, 40);
        idle(5);
        chk("lit_1234_data", {16'd0, bus_if.data_rec}, 32'h1234);
        chk("lit_1234_cd", {31'd0, bus_if.cd_rec}, 32'd1);

        // Back-to-back words.
        send_word(1'b0, 16'hFFFF, FAULT_NONE, 0, 6'd0, 40);
        send_word(1'b1, 16'h0000, FAULT_NONE, 0, 6'd0, 40);
        idle(5);
        chk("lit_b2b_data", {16'd0, bus_if.data_rec}, 32'h0000);
        chk("lit_b2b_cd", {31'd0, bus_if.cd_rec}, 32'd1);
        idle(20);

        // Inverted parity pair.
        send_word(1'b1, 16'h1234, FAULT_PARITY, 0, 6'd0, 40);
        idle(20);
        chk("lit_parity_data", {16'd0, bus_if.data_rec}, 32'h1234);

        // Bad sync 0,1,0,1,0,1 then a valid word.
        send_word(1'b1, 16'h0000, FAULT_SYNC, 0, 6'b010101, 40);
        chk("busy_after_bad_sync", {31'd0, bus_if.busy_rec}, 32'd0);
        idle(20);
        chk("lit_bad_sync_hold", {16'd0, bus_if.data_rec}, 32'h1234);
        send_word(1'b0, 16'hABCD, FAULT_NONE, 0, 6'd0, 40);
        idle(5);
        chk("lit_abcd_data", {16'd0, bus_if.data_rec}, 32'hABCD);
        idle(15);

        // Pair 11 at data bit 7: bit reads as 1, word flagged.
        send_word(1'b1, 16'h1234, FAULT_PAIR11, 7, 6'd0, 40);
        idle(5);
        chk("lit_pair11_data", {16'd0, bus_if.data_rec}, 32'h12B4);
        idle(15);

        // Reset at half-bit 20 aborts the word silently.
        send_word(1'b1, 16'h5555, FAULT_NONE, 0, 6'd0, 20);
        reset = 1'b1;
        exp_q.delete();
        m_data = 16'h0000;
        m_cd   = 1'b0;
        idle(4);
        reset = 1'b0;
        idle(6);
        send_word(1'b1, 16'hA5A5, FAULT_NONE, 0, 6'd0, 40);
        idle(5);
        chk("lit_a5a5_data", {16'd0, bus_if.data_rec}, 32'hA5A5);
        chk("lit_a5a5_cd", {31'd0, bus_if.cd_rec}, 32'd1);
        idle(15);

        // Randomized words, faults and gaps.
        for (int w = 0; w < 40; w++) begin
            fault = $urandom_range(0, 5);
            if (fault > FAULT_SYNC) fault = FAULT_NONE;
            pat = 6'($urandom_range(0, 63));
            if (pat == 6'b000111 || pat == 6'b111000) pat = 6'b010101;
            send_word(1'($urandom_range(0, 1)), 16'($urandom), fault,
                      $urandom_range(0, 15), pat, 40);
            if (fault == FAULT_SYNC) gap = $urandom_range(16, 40);
            else if ($urandom_range(0, 2) == 0) gap = 0;
            else gap = $urandom_range(1, 30);
            if (gap > 0) idle(gap);
        end

        idle(400);
        chk("pending_events", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
